fpu_issue_ctrl: RTL and testbench

FPU_ISSUE_CTRL -- requirements
Module: fpu_issue_ctrl

---
 rtl/fpu_issue_ctrl.sv | 136 +++++++++++++
 tb/tb_fpu_issue_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_issue_ctrl.sv
// FPU issue control: hazard scoreboard, writeback reservation shifter and
// divide/sqrt occupancy tracking for a single in-order FP issue port.
package fpu_issue_pkg;
  typedef enum logic [3:0] {
    FPU_NOP, FPU_ADD, FPU_SUB, FPU_MUL, FPU_MADD, FPU_MSUB, FPU_NMADD, FPU_NMSUB,
    F_DIV, F_SQRT, FPU_MIN, FPU_MAX, FPU_CMP_EQ, FPU_CMP_LT, FPU_CMP_LE, FPU_CVT
  } fpu_op_e;
endpackage

module fpu_issue_ctrl
  import fpu_issue_pkg::*;
#(
  parameter int unsigned LAT_FMA     = 3,
  parameter int unsigned LAT_DIVSQRT = 12
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       flush_i,
  input  logic       op_valid_i,
  input  fpu_op_e    op_i,
  input  logic [4:0] rs1_i,
  input  logic [4:0] rs2_i,
  input  logic [4:0] rs3_i,
  input  logic [4:0] rd_i,
  input  logic       rs1_fp_i,
  input  logic       rs2_fp_i,
  input  logic       rs3_fp_i,
  input  logic       rd_fp_i,
  output logic       op_ready_o,
  output logic       fma_start_o,
  output logic       divsqrt_start_o,
  output logic       misc_start_o,
  output logic       wb_valid_o,
  output logic [4:0] wb_rd_o,
  output logic       wb_fp_o,
  output logic       busy_o
);

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       fp;
  } slot_t;

  // Slot k holds the op writing back k cycles from now; slot 0 drives the
  // writeback outputs directly.
  slot_t       res_q [LAT_DIVSQRT];
  slot_t       res_d [LAT_DIVSQRT];
  logic [31:0] sb_q, sb_d;
  logic [4:0]  ds_cnt_q;
  logic        init_q;

  logic       is_nop, is_fma, is_ds, is_misc;
  logic [4:0] lat;
  logic       slot_taken, raw, waw, ds_busy, accept;

  always_comb begin
    is_nop  = 1'b0;
    is_fma  = 1'b0;
    is_ds   = 1'b0;
    is_misc = 1'b0;
    lat     = 5'd1;
    unique case (op_i)
      FPU_NOP: is_nop = 1'b1;
      FPU_ADD, FPU_SUB, FPU_MUL, FPU_MADD, FPU_MSUB, FPU_NMADD, FPU_NMSUB: begin
        is_fma = 1'b1;
        lat    = 5'(LAT_FMA);
      end
      F_DIV, F_SQRT: begin
        is_ds = 1'b1;
        lat   = 5'(LAT_DIVSQRT);
      end
      default: is_misc = 1'b1;
    endcase
  end

  always_comb begin
    // A latency of LAT_DIVSQRT lands beyond the last stored slot, which is always free.
    slot_taken = 1'b0;
    for (int unsigned k = 0; k < LAT_DIVSQRT; k++) begin
      if (5'(k) == lat) slot_taken = res_q[k].v;
    end
    raw     = (rs1_fp_i && sb_q[rs1_i]) || (rs2_fp_i && sb_q[rs2_i]) ||
              (rs3_fp_i && sb_q[rs3_i]);
    waw     = rd_fp_i && sb_q[rd_i];
    ds_busy = (ds_cnt_q != 5'd0);
    op_ready_o = !rst_i && !init_q && !flush_i &&
                 (is_nop || !(raw || waw || slot_taken || (is_ds && ds_busy)));
    accept          = op_valid_i && op_ready_o && !is_nop;
    fma_start_o     = accept && is_fma;
    divsqrt_start_o = accept && is_ds;
    misc_start_o    = accept && is_misc;
  end

  always_comb begin
    for (int unsigned k = 0; k < LAT_DIVSQRT; k++) begin
      res_d[k] = (k + 1 < LAT_DIVSQRT) ? res_q[k + 1] : '0;
    end
    // Writing at lat-1 of the shifted image places the op at slot lat-1 next
    // cycle, i.e. writeback exactly lat cycles after accept.
    if (accept) begin
      for (int unsigned k = 0; k < LAT_DIVSQRT; k++) begin
        if (5'(k + 1) == lat) res_d[k] = '{v: 1'b1, rd: rd_i, fp: rd_fp_i};
      end
    end
    sb_d = sb_q;
    if (res_q[0].v && res_q[0].fp) sb_d[res_q[0].rd] = 1'b0;
    if (accept && rd_fp_i) sb_d[rd_i] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      for (int unsigned k = 0; k < LAT_DIVSQRT; k++) res_q[k] <= '0;
      sb_q     <= '0;
      ds_cnt_q <= '0;
      init_q   <= rst_i;
    end else begin
      for (int unsigned k = 0; k < LAT_DIVSQRT; k++) res_q[k] <= res_d[k];
      sb_q   <= sb_d;
      init_q <= 1'b0;
      if (accept && is_ds) ds_cnt_q <= 5'(LAT_DIVSQRT - 1);
      else if (ds_busy)    ds_cnt_q <= ds_cnt_q - 5'd1;
    end
  end

  always_comb begin
    wb_valid_o = res_q[0].v;
    wb_rd_o    = res_q[0].rd;
    wb_fp_o    = res_q[0].fp;
    busy_o     = ds_busy;
    for (int unsigned k = 0; k < LAT_DIVSQRT; k++) begin
      if (res_q[k].v) busy_o = 1'b1;
    end
  end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Bench for fpu_issue_ctrl: directed latency scenarios plus random traffic
// checked against a cycle-indexed writeback/scoreboard model.
module tb_fpu_issue_ctrl;
  import fpu_issue_pkg::*;

  localparam int LF = 3;
  localparam int LD = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, flush, op_valid;
  fpu_op_e    op;
  logic [4:0] rs1, rs2, rs3, rd;
  logic       rs1_fp, rs2_fp, rs3_fp, rd_fp;
  logic       op_ready, fma_start, divsqrt_start, misc_start;
  logic       wb_valid, wb_fp, busy;
  logic [4:0] wb_rd;

  fpu_issue_ctrl #(.LAT_FMA(LF), .LAT_DIVSQRT(LD)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .op_valid_i(op_valid), .op_i(op),
    .rs1_i(rs1), .rs2_i(rs2), .rs3_i(rs3), .rd_i(rd),
    .rs1_fp_i(rs1_fp), .rs2_fp_i(rs2_fp), .rs3_fp_i(rs3_fp), .rd_fp_i(rd_fp),
    .op_ready_o(op_ready), .fma_start_o(fma_start), .divsqrt_start_o(divsqrt_start),
    .misc_start_o(misc_start), .wb_valid_o(wb_valid), .wb_rd_o(wb_rd),
    .wb_fp_o(wb_fp), .busy_o(busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model: writebacks keyed by absolute cycle, per-register pending-until cycle.
  int cyc;
  int pend [32];
  int ds_free;
  bit init_m;
  int sched_rd [int];
  bit sched_fp [int];

  function automatic int cls_of(input fpu_op_e o);
    if (o == FPU_NOP) return 0;
    if (o inside {FPU_ADD, FPU_SUB, FPU_MUL, FPU_MADD, FPU_MSUB, FPU_NMADD, FPU_NMSUB}) return 1;
    if (o inside {F_DIV, F_SQRT}) return 2;
    return 3;
  endfunction

  function automatic int lat_of(input fpu_op_e o);
    case (cls_of(o))
      1: return LF;
      2: return LD;
      default: return 1;
    endcase
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) pend[i] = -1;
    sched_rd.delete();
    sched_fp.delete();
    ds_free = 0;
  endtask

  task automatic step(input bit fl, input bit rs, input bit v, input fpu_op_e o,
                      input logic [4:0] a, input logic [4:0] b, input logic [4:0] c,
                      input logic [4:0] d, input bit fa, input bit fb, input bit fc,
                      input bit fd, output bit m_acc, output bit d_acc);
    bit rdy, eb, ewb;
    int L, cl;
    flush = fl; rst = rs; op_valid = v; op = o;
    rs1 = a; rs2 = b; rs3 = c; rd = d;
    rs1_fp = fa; rs2_fp = fb; rs3_fp = fc; rd_fp = fd;
    #3;
    L  = lat_of(o);
    cl = cls_of(o);
    if (rs || init_m || fl) rdy = 0;
    else if (cl == 0) rdy = 1;
    else begin
      rdy = 1;
      if (fa && pend[a] >= cyc) rdy = 0;
      if (fb && pend[b] >= cyc) rdy = 0;
      if (fc && pend[c] >= cyc) rdy = 0;
      if (fd && pend[d] >= cyc) rdy = 0;
      if (sched_rd.exists(cyc + L)) rdy = 0;
      if (cl == 2 && cyc < ds_free) rdy = 0;
    end
    m_acc = v && rdy;
    d_acc = v && (op_ready === 1'b1);
    eb = (cyc < ds_free);
    foreach (sched_rd[k]) if (k >= cyc) eb = 1;
    ewb = sched_rd.exists(cyc);
    check_eq("ready", op_ready, rdy);
    check_eq("fma_start", fma_start, m_acc && cl == 1);
    check_eq("ds_start", divsqrt_start, m_acc && cl == 2);
    check_eq("misc_start", misc_start, m_acc && cl == 3);
    check_eq("wb_valid", wb_valid, ewb);
    if (ewb) begin
      check_eq("wb_rd", wb_rd, sched_rd[cyc]);
      check_eq("wb_fp", wb_fp, sched_fp[cyc]);
      sched_rd.delete(cyc);
      sched_fp.delete(cyc);
    end
    check_eq("busy", busy, eb);
    if (rs) begin
      model_clear();
      init_m = 1;
    end else begin
      init_m = 0;
      if (fl) model_clear();
      else if (m_acc && cl != 0) begin
        sched_rd[cyc + L] = d;
        sched_fp[cyc + L] = fd;
        if (fd) pend[d] = cyc + L;
        if (cl == 2) ds_free = cyc + L;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit fl);
    bit ma, da;
    for (int i = 0; i < n; i++) step(fl, 0, 0, FPU_NOP, 0, 0, 0, 0, 0, 0, 0, 0, ma, da);
  endtask

  // Presents an op until the DUT takes it; returns the number of stall cycles.
  task automatic issue(input fpu_op_e o, input logic [4:0] a, input logic [4:0] b,
                       input logic [4:0] d, input bit fa, input bit fb, input bit fd,
                       output int stalls);
    bit ma, da;
    stalls = 0;
    step(0, 0, 1, o, a, b, 0, d, fa, fb, 0, fd, ma, da);
    while (!da && stalls < 64) begin
      stalls++;
      step(0, 0, 1, o, a, b, 0, d, fa, fb, 0, fd, ma, da);
    end
  endtask

  initial begin
    int s;
    bit ma, da, have, pfl, prs;
    fpu_op_e ro;
    logic [4:0] ra, rb, rc, rdd;
    bit fa, fb, fc, fd;

    rst = 1; flush = 0; op_valid = 0; op = FPU_NOP;
    rs1 = 0; rs2 = 0; rs3 = 0; rd = 0;
    rs1_fp = 0; rs2_fp = 0; rs3_fp = 0; rd_fp = 0;
    repeat (2) @(posedge clk);
    #1;
    model_clear();
    cyc = 0;
    init_m = 1;

    // Cycle right after reset: an ADD is offered but nothing may happen.
    step(0, 0, 1, FPU_ADD, 1, 2, 0, 3, 1, 1, 0, 1, ma, da);
    check_eq("rst_wb_rd", wb_rd, 0);

    issue(FPU_ADD, 0, 0, 3, 0, 0, 1, s);  check_eq("add_acc", s, 0);
    issue(FPU_SUB, 3, 0, 4, 1, 0, 1, s);  check_eq("add_raw_wait", s, 3);
    idle(6, 0);

    issue(F_DIV, 1, 2, 5, 1, 1, 1, s);    check_eq("div_acc", s, 0);
    issue(FPU_ADD, 5, 0, 10, 1, 0, 1, s); check_eq("div_raw_wait", s, 12);
    idle(5, 0);

    issue(F_DIV, 1, 2, 6, 1, 1, 1, s);    check_eq("div2_acc", s, 0);
    issue(F_SQRT, 1, 0, 7, 1, 0, 1, s);   check_eq("sqrt_wait", s, 11);
    idle(14, 0);

    issue(FPU_MUL, 1, 2, 8, 1, 1, 1, s);  check_eq("mul_acc", s, 0);
    idle(1, 0);
    issue(FPU_MIN, 1, 2, 9, 1, 1, 1, s);  check_eq("min_slot_wait", s, 1);
    idle(3, 0);

    issue(FPU_CMP_LE, 1, 2, 7, 1, 1, 0, s); check_eq("cmp_acc", s, 0);
    issue(FPU_ADD, 7, 0, 7, 1, 0, 1, s);    check_eq("cmp_no_sb", s, 0);
    idle(5, 0);

    issue(F_DIV, 1, 2, 5, 1, 1, 1, s);    check_eq("div3_acc", s, 0);
    idle(3, 0);
    idle(1, 1);
    check_eq("flush_busy", busy, 0);
    issue(FPU_ADD, 5, 0, 11, 1, 0, 1, s); check_eq("post_flush_acc", s, 0);
    idle(5, 0);

    issue(F_DIV, 1, 2, 12, 1, 1, 1, s);   check_eq("div4_acc", s, 0);
    idle(2, 0);
    step(0, 1, 0, FPU_NOP, 0, 0, 0, 0, 0, 0, 0, 0, ma, da);
    idle(15, 0);

    have = 0;
    ro = FPU_NOP; ra = 0; rb = 0; rc = 0; rdd = 0; fa = 0; fb = 0; fc = 0; fd = 0;
    for (int i = 0; i < 2500; i++) begin
      if (!have && $urandom_range(0, 3) != 0) begin
        ro  = fpu_op_e'($urandom_range(0, 15));
        ra  = 5'($urandom_range(0, 7));
        rb  = 5'($urandom_range(0, 7));
        rc  = 5'($urandom_range(0, 7));
        rdd = 5'($urandom_range(0, 7));
        fa = 1'($urandom); fb = 1'($urandom); fc = 1'($urandom); fd = 1'($urandom);
        have = 1;
      end
      pfl = ($urandom_range(0, 59) == 0);
      prs = ($urandom_range(0, 399) == 0);
      step(pfl, prs, have, ro, ra, rb, rc, rdd, fa, fb, fc, fd, ma, da);
      if (ma || prs) have = 0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
